// File: rtl/cali_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cali_seq_ctrl
//
// Calibration sequencer for the piecewise DCD-RLS/LMS distortion-calibration
// core. After START it holds the core in reset, runs an LMS acquisition
// phase, then switches the core to RLS tracking. While tracking, quantized
// |error| samples are summed over fixed windows of 2^WIN_LOG2 valid samples
// to declare lock, detect loss of lock, and flag a tracking timeout.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   START, ABORT        one-cycle control pulses (ABORT has priority)
//   SAMPLE_VLD, ERR_ABS error-magnitude sample stream
//   CFG_*               configuration, latched on an accepted START
//   CORE_NRST/EN/MODE_RLS/PSEGS   pins driving the calibration core
//   LOCKED, FAIL, BUSY, STATE     status
//   RELOCK_CNT          LOCKED->RLS_TRK transitions since START (saturating)
// -----------------------------------------------------------------------------
module cali_seq_ctrl #(
    parameter int EW       = 12,
    parameter int CW       = 16,
    parameter int WIN_LOG2 = 4,
    parameter int RST_CYC  = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   ABORT,
    input  logic                   SAMPLE_VLD,
    input  logic [EW-1:0]          ERR_ABS,
    input  logic [1:0]             CFG_PSEGS,
    input  logic [CW-1:0]          CFG_LMS_CYC,
    input  logic [CW-1:0]          CFG_TIMEOUT,
    input  logic [EW+WIN_LOG2-1:0] CFG_LOCK_TH,
    input  logic [EW+WIN_LOG2-1:0] CFG_UNLOCK_TH,
    input  logic [3:0]             CFG_CONV_N,
    input  logic                   CFG_FREEZE,
    output logic                   CORE_NRST,
    output logic                   CORE_EN,
    output logic                   CORE_MODE_RLS,
    output logic [1:0]             CORE_PSEGS,
    output logic                   LOCKED,
    output logic                   FAIL,
    output logic                   BUSY,
    output logic [2:0]             STATE,
    output logic [7:0]             RELOCK_CNT
);

    // Accumulator width: 2^WIN_LOG2 samples of EW bits can never overflow it.
    localparam int AW = EW + WIN_LOG2;

    localparam logic [CW-1:0]       RST_LAST = CW'(RST_CYC - 1);
    localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CORE_RST = 3'd1,
        S_LMS_ACQ  = 3'd2,
        S_RLS_TRK  = 3'd3,
        S_LOCKED   = 3'd4,
        S_FAIL     = 3'd5
    } state_e;

    state_e              state_q,     state_d;
    logic [1:0]          psegs_q,     psegs_d;
    logic [CW-1:0]       lms_cyc_q,   lms_cyc_d;
    logic [CW-1:0]       timeout_q,   timeout_d;
    logic [AW-1:0]       lock_th_q,   lock_th_d;
    logic [AW-1:0]       unlock_th_q, unlock_th_d;
    logic [3:0]          conv_n_q,    conv_n_d;
    logic                freeze_q,    freeze_d;
    logic [7:0]          relock_q,    relock_d;
    logic [CW-1:0]       cnt_q,       cnt_d;      // CORE_RST cycles / LMS samples
    logic [WIN_LOG2-1:0] win_smp_q,   win_smp_d;  // valid samples in current window
    logic [AW-1:0]       acc_q,       acc_d;      // window error sum
    logic [3:0]          conv_cnt_q,  conv_cnt_d; // consecutive converged windows
    logic [CW-1:0]       win_cnt_q,   win_cnt_d;  // windows spent in RLS_TRK

    // Helpers for the next-state logic.
    logic [AW-1:0] sum;
    logic          win_close;
    logic [4:0]    conv_inc;
    logic [4:0]    conv_need;
    logic [CW-1:0] win_inc;
    logic [CW-1:0] cnt_inc;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            psegs_q     <= '0;
            lms_cyc_q   <= '0;
            timeout_q   <= '0;
            lock_th_q   <= '0;
            unlock_th_q <= '0;
            conv_n_q    <= '0;
            freeze_q    <= 1'b0;
            relock_q    <= '0;
            cnt_q       <= '0;
            win_smp_q   <= '0;
            acc_q       <= '0;
            conv_cnt_q  <= '0;
            win_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            psegs_q     <= psegs_d;
            lms_cyc_q   <= lms_cyc_d;
            timeout_q   <= timeout_d;
            lock_th_q   <= lock_th_d;
            unlock_th_q <= unlock_th_d;
            conv_n_q    <= conv_n_d;
            freeze_q    <= freeze_d;
            relock_q    <= relock_d;
            cnt_q       <= cnt_d;
            win_smp_q   <= win_smp_d;
            acc_q       <= acc_d;
            conv_cnt_q  <= conv_cnt_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // the case statement can infer a latch.
        state_d     = state_q;
        psegs_d     = psegs_q;
        lms_cyc_d   = lms_cyc_q;
        timeout_d   = timeout_q;
        lock_th_d   = lock_th_q;
        unlock_th_d = unlock_th_q;
        conv_n_d    = conv_n_q;
        freeze_d    = freeze_q;
        relock_d    = relock_q;
        cnt_d       = cnt_q;
        win_smp_d   = win_smp_q;
        acc_d       = acc_q;
        conv_cnt_d  = conv_cnt_q;
        win_cnt_d   = win_cnt_q;

        sum       = acc_q + AW'(ERR_ABS);
        win_close = SAMPLE_VLD && (win_smp_q == WIN_LAST);
        conv_inc  = {1'b0, conv_cnt_q} + 5'd1;
        conv_need = (conv_n_q == 4'd0) ? 5'd1 : {1'b0, conv_n_q};
        win_inc   = win_cnt_q + CW'(1);
        cnt_inc   = cnt_q + CW'(1);

        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            // Window monitor runs in both tracking states, frozen or not.
            if ((state_q == S_RLS_TRK || state_q == S_LOCKED) && SAMPLE_VLD) begin
                if (win_close) begin
                    acc_d     = '0;
                    win_smp_d = '0;
                end else begin
                    acc_d     = sum;
                    win_smp_d = win_smp_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE, S_FAIL: begin
                    if (START) begin
                        psegs_d     = CFG_PSEGS;
                        lms_cyc_d   = CFG_LMS_CYC;
                        timeout_d   = CFG_TIMEOUT;
                        lock_th_d   = CFG_LOCK_TH;
                        unlock_th_d = CFG_UNLOCK_TH;
                        conv_n_d    = CFG_CONV_N;
                        freeze_d    = CFG_FREEZE;
                        relock_d    = '0;
                        conv_cnt_d  = '0;
                        win_cnt_d   = '0;
                        state_d     = S_CORE_RST;
                    end
                end

                S_CORE_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = (lms_cyc_q == '0) ? S_RLS_TRK : S_LMS_ACQ;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                S_LMS_ACQ: begin
                    if (SAMPLE_VLD) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == lms_cyc_q) begin
                            state_d = S_RLS_TRK;
                        end
                    end
                end

                S_RLS_TRK: begin
                    if (win_close) begin
                        if (sum <= lock_th_q) begin
                            conv_cnt_d = conv_inc[3:0];
                        end else begin
                            conv_cnt_d = '0;
                        end
                        // Lock is checked first so it wins over a same-window timeout.
                        if ((sum <= lock_th_q) && (conv_inc >= conv_need)) begin
                            state_d = S_LOCKED;
                        end else begin
                            win_cnt_d = win_inc;
                            if ((timeout_q != '0) && (win_inc == timeout_q)) begin
                                state_d = S_FAIL;
                            end
                        end
                    end
                end

                S_LOCKED: begin
                    if (win_close && (sum > unlock_th_q)) begin
                        state_d    = S_RLS_TRK;
                        conv_cnt_d = '0;
                        win_cnt_d  = '0;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Every state entry starts with fresh sample/cycle counters and an
        // empty window.
        if (state_d != state_q) begin
            cnt_d     = '0;
            win_smp_d = '0;
            acc_d     = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Moore outputs (CORE_EN additionally gates on SAMPLE_VLD)
    // -------------------------------------------------------------------------
    always_comb begin
        CORE_NRST     = 1'b1;
        CORE_MODE_RLS = 1'b0;
        CORE_EN       = 1'b0;
        LOCKED        = 1'b0;
        FAIL          = 1'b0;
        BUSY          = 1'b0;
        case (state_q)
            S_IDLE: begin
                CORE_NRST = 1'b0;
            end
            S_CORE_RST: begin
                CORE_NRST = 1'b0;
                BUSY      = 1'b1;
            end
            S_LMS_ACQ: begin
                CORE_EN = SAMPLE_VLD;
                BUSY    = 1'b1;
            end
            S_RLS_TRK: begin
                CORE_MODE_RLS = 1'b1;
                CORE_EN       = SAMPLE_VLD;
                BUSY          = 1'b1;
            end
            S_LOCKED: begin
                CORE_MODE_RLS = 1'b1;
                CORE_EN       = SAMPLE_VLD && !freeze_q;
                LOCKED        = 1'b1;
            end
            S_FAIL: begin
                // Core stays out of reset so its coefficients remain readable.
                FAIL = 1'b1;
            end
            default: begin
                CORE_NRST = 1'b0;
            end
        endcase
        CORE_PSEGS = psegs_q;
        STATE      = state_q;
        RELOCK_CNT = relock_q;
    end

endmodule

// File: tb/tb_cali_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cali_seq_ctrl: reset checks, a table of tracking
// scenarios, hand-written multi-cycle sequences, and randomized runs checked
// against a sample-list model of the calibration timeline.
// -----------------------------------------------------------------------------
module tb_cali_seq_ctrl;

    localparam int EW       = 12;
    localparam int CW       = 16;
    localparam int WIN_LOG2 = 4;
    localparam int RST_CYC  = 4;
    localparam int WIN_LEN  = 1 << WIN_LOG2;
    localparam int NE       = 600;

    localparam int ST_IDLE = 0, ST_RST = 1, ST_LMS = 2, ST_RLS = 3, ST_LOCK = 4, ST_FAIL = 5;

    logic                   CLK = 1'b0;
    logic                   RST, START, ABORT, SAMPLE_VLD;
    logic [EW-1:0]          ERR_ABS;
    logic [1:0]             CFG_PSEGS;
    logic [CW-1:0]          CFG_LMS_CYC, CFG_TIMEOUT;
    logic [EW+WIN_LOG2-1:0] CFG_LOCK_TH, CFG_UNLOCK_TH;
    logic [3:0]             CFG_CONV_N;
    logic                   CFG_FREEZE;
    logic                   CORE_NRST, CORE_EN, CORE_MODE_RLS;
    logic [1:0]             CORE_PSEGS;
    logic                   LOCKED, FAIL, BUSY;
    logic [2:0]             STATE;
    logic [7:0]             RELOCK_CNT;

    int checks   = 0;
    int failures = 0;

    cali_seq_ctrl #(.EW(EW), .CW(CW), .WIN_LOG2(WIN_LOG2), .RST_CYC(RST_CYC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .SAMPLE_VLD(SAMPLE_VLD), .ERR_ABS(ERR_ABS),
        .CFG_PSEGS(CFG_PSEGS), .CFG_LMS_CYC(CFG_LMS_CYC), .CFG_TIMEOUT(CFG_TIMEOUT),
        .CFG_LOCK_TH(CFG_LOCK_TH), .CFG_UNLOCK_TH(CFG_UNLOCK_TH),
        .CFG_CONV_N(CFG_CONV_N), .CFG_FREEZE(CFG_FREEZE),
        .CORE_NRST(CORE_NRST), .CORE_EN(CORE_EN), .CORE_MODE_RLS(CORE_MODE_RLS),
        .CORE_PSEGS(CORE_PSEGS), .LOCKED(LOCKED), .FAIL(FAIL), .BUSY(BUSY),
        .STATE(STATE), .RELOCK_CNT(RELOCK_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [EW-1:0]          err;
        logic [EW+WIN_LOG2-1:0] lock_th;
        logic [3:0]             conv_n;
        logic [CW-1:0]          timeout;
        int                     n_smp;
        int                     exp_st;
    } vec_t;

    vec_t vecs [8];

    bit            vld_a [NE];
    logic [EW-1:0] err_a [NE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_cfg(input int lms, input int ps, input int tmo, input int lth,
                             input int uth, input int cnv, input bit frz);
        ABORT = 1'b1;
        step();
        ABORT         = 1'b0;
        CFG_LMS_CYC   = CW'(lms);
        CFG_PSEGS     = 2'(ps);
        CFG_TIMEOUT   = CW'(tmo);
        CFG_LOCK_TH   = (EW+WIN_LOG2)'(lth);
        CFG_UNLOCK_TH = (EW+WIN_LOG2)'(uth);
        CFG_CONV_N    = 4'(cnv);
        CFG_FREEZE    = frz;
        SAMPLE_VLD    = 1'b0;
        START         = 1'b1;
        step();
        START = 1'b0;
    endtask

    function automatic int exp_state_at(input int e, input int e_rls, input int ev, input int ev_st);
        if (e < RST_CYC)               return ST_RST;
        if (e_rls < 0 || e < e_rls)    return ST_LMS;
        if (ev < 0 || e < ev)          return ST_RLS;
        return ev_st;
    endfunction

    initial begin
        vecs[0] = '{12'd3,    16'd48,    4'd2, 16'd0, 32, ST_LOCK};
        vecs[1] = '{12'd3,    16'd47,    4'd2, 16'd0, 64, ST_RLS};
        vecs[2] = '{12'd3,    16'd0,     4'd2, 16'd5, 80, ST_FAIL};
        vecs[3] = '{12'd3,    16'd48,    4'd0, 16'd0, 16, ST_LOCK};
        vecs[4] = '{12'd3,    16'd48,    4'd1, 16'd1, 16, ST_LOCK};
        vecs[5] = '{12'd0,    16'd0,     4'd3, 16'd0, 48, ST_LOCK};
        vecs[6] = '{12'd4095, 16'd65520, 4'd1, 16'd0, 16, ST_LOCK};
        vecs[7] = '{12'd4095, 16'd65519, 4'd1, 16'd2, 32, ST_FAIL};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; SAMPLE_VLD = 1'b0; ERR_ABS = '0;
        CFG_PSEGS = '0; CFG_LMS_CYC = '0; CFG_TIMEOUT = '0; CFG_LOCK_TH = '0;
        CFG_UNLOCK_TH = '0; CFG_CONV_N = '0; CFG_FREEZE = 1'b0;

        // ---- Reset values ----
        step();
        step();
        RST = 1'b0;
        check("rst_state", STATE, ST_IDLE);
        check("rst_nrst", CORE_NRST, 0);
        check("rst_en", CORE_EN, 0);
        check("rst_mode", CORE_MODE_RLS, 0);
        check("rst_psegs", CORE_PSEGS, 0);
        check("rst_flags", {LOCKED, FAIL, BUSY}, 0);
        check("rst_relock", RELOCK_CNT, 0);

        // ---- Reset pulse, LMS length, PSEGS latching (constant SAMPLE_VLD) ----
        ABORT = 1'b1; step(); ABORT = 1'b0;
        CFG_LMS_CYC = 16'd10; CFG_PSEGS = 2'd2; CFG_TIMEOUT = '0;
        CFG_LOCK_TH = '0; CFG_UNLOCK_TH = '1; CFG_CONV_N = 4'd1; CFG_FREEZE = 1'b0;
        SAMPLE_VLD = 1'b1; ERR_ABS = 12'd7;
        START = 1'b1; step(); START = 1'b0;
        check("t1_psegs_latched", CORE_PSEGS, 2);
        check("t1_busy", BUSY, 1);
        CFG_PSEGS = 2'd1;
        for (int i = 0; i < RST_CYC; i++) begin
            if (i > 0) step();
            check("t1_nrst_low", CORE_NRST, 0);
        end
        step();
        check("t1_nrst_rise", CORE_NRST, 1);
        check("t1_en_lms", CORE_EN, 1);
        for (int i = 1; i < 10; i++) begin
            check("t1_mode_lms", CORE_MODE_RLS, 0);
            step();
        end
        check("t1_mode_pre", CORE_MODE_RLS, 0);
        step();
        check("t1_mode_rise", CORE_MODE_RLS, 1);
        check("t1_psegs_hold", CORE_PSEGS, 2);

        // ---- Table of tracking scenarios (LMS_CYC=0 goes straight to RLS) ----
        foreach (vecs[i]) begin
            start_cfg(0, 0, int'(vecs[i].timeout), int'(vecs[i].lock_th), 65535,
                      int'(vecs[i].conv_n), 1'b0);
            repeat (RST_CYC - 1) step();
            check("tbl_in_rst", STATE, ST_RST);
            step();
            check("tbl_rls_entry", STATE, ST_RLS);
            SAMPLE_VLD = 1'b1;
            ERR_ABS    = vecs[i].err;
            repeat (vecs[i].n_smp - 1) step();
            check("tbl_pre", STATE, ST_RLS);
            step();
            check("tbl_state", STATE, vecs[i].exp_st);
            check("tbl_locked", LOCKED, vecs[i].exp_st == ST_LOCK);
            check("tbl_fail", FAIL, vecs[i].exp_st == ST_FAIL);
            check("tbl_busy", BUSY, vecs[i].exp_st == ST_RLS);
            check("tbl_nrst", CORE_NRST, 1);
            check("tbl_en", CORE_EN, vecs[i].exp_st != ST_FAIL);
            if (vecs[i].exp_st == ST_FAIL) begin
                SAMPLE_VLD = 1'b0;
                START = 1'b1; step(); START = 1'b0;
                check("tbl_fail_restart", STATE, ST_RST);
            end
            SAMPLE_VLD = 1'b0;
        end

        // ---- Freeze while locked, then loss of lock ----
        start_cfg(0, 3, 0, 48, 1000, 1, 1'b1);
        repeat (RST_CYC) step();
        SAMPLE_VLD = 1'b1; ERR_ABS = 12'd3;
        repeat (WIN_LEN) step();
        check("frz_locked", STATE, ST_LOCK);
        for (int i = 0; i < WIN_LEN; i++) begin
            step();
            check("frz_en_low", CORE_EN, 0);
        end
        check("frz_still_locked", STATE, ST_LOCK);
        ERR_ABS = 12'd100;
        repeat (WIN_LEN - 1) step();
        check("frz_pre_unlock", STATE, ST_LOCK);
        check("frz_en_low2", CORE_EN, 0);
        step();
        check("frz_unlock", STATE, ST_RLS);
        check("frz_relock", RELOCK_CNT, 1);
        check("frz_en_vld1", CORE_EN, 1);
        SAMPLE_VLD = 1'b0; #1;
        check("frz_en_vld0", CORE_EN, 0);

        // ---- Synchronous reset mid-operation ----
        RST = 1'b1; step(); RST = 1'b0;
        check("mid_rst_state", STATE, ST_IDLE);
        check("mid_rst_relock", RELOCK_CNT, 0);
        check("mid_rst_psegs", CORE_PSEGS, 0);
        check("mid_rst_nrst", CORE_NRST, 0);

        // ---- Toggling SAMPLE_VLD in LMS_ACQ ----
        start_cfg(8, 1, 0, 0, 65535, 1, 1'b0);
        repeat (RST_CYC) step();
        check("t5_lms", STATE, ST_LMS);
        for (int k = 0; k < 16; k++) begin
            SAMPLE_VLD = k[0];
            step();
            if (k < 15) check("t5_en_mirror", CORE_EN, k[0]);
            if (k == 14) check("t5_pre_exit", STATE, ST_LMS);
            if (k == 15) check("t5_exit", STATE, ST_RLS);
        end

        // ---- START while busy is ignored ----
        start_cfg(10, 3, 0, 0, 65535, 1, 1'b0);
        repeat (RST_CYC) step();
        CFG_PSEGS = 2'd0;
        START = 1'b1; step(); START = 1'b0;
        check("busy_start_state", STATE, ST_LMS);
        check("busy_start_psegs", CORE_PSEGS, 3);

        // ---- ABORT on a lock-qualifying window close ----
        start_cfg(0, 0, 0, 48, 65535, 1, 1'b0);
        repeat (RST_CYC) step();
        SAMPLE_VLD = 1'b1; ERR_ABS = 12'd3;
        repeat (WIN_LEN - 1) step();
        check("abort_pre", STATE, ST_RLS);
        ABORT = 1'b1; step(); ABORT = 1'b0;
        check("abort_state", STATE, ST_IDLE);
        check("abort_locked", LOCKED, 0);
        SAMPLE_VLD = 1'b0;

        // ---- Randomized runs against the sample-list model ----
        for (int t = 0; t < 20; t++) begin
            int lms, cnv, tmo, th, pct, need, e_rls, ev, ev_st, n, wn, wsum, streak, wins, last, est;
            bit frz;
            lms = $urandom_range(0, 20);
            cnv = $urandom_range(0, 3);
            tmo = $urandom_range(0, 6);
            th  = $urandom_range(40, 90);
            pct = $urandom_range(50, 100);
            frz = 1'($urandom_range(0, 1));
            for (int e = 0; e < NE; e++) begin
                vld_a[e] = ($urandom_range(1, 100) <= pct);
                err_a[e] = EW'($urandom_range(0, 7));
            end

            // RLS entry: the lms-th valid sample seen while in LMS_ACQ.
            e_rls = -1;
            if (lms == 0) begin
                e_rls = RST_CYC;
            end else begin
                n = 0;
                for (int e = RST_CYC + 1; e < NE && e_rls < 0; e++) begin
                    if (vld_a[e]) begin
                        n++;
                        if (n == lms) e_rls = e;
                    end
                end
            end

            // Group following valid samples into windows and apply lock/timeout rules.
            ev = -1; ev_st = ST_RLS;
            if (e_rls >= 0) begin
                need = (cnv == 0) ? 1 : cnv;
                wn = 0; wsum = 0; streak = 0; wins = 0;
                for (int e = e_rls + 1; e < NE && ev < 0; e++) begin
                    if (vld_a[e]) begin
                        wsum += int'(err_a[e]);
                        wn++;
                        if (wn == WIN_LEN) begin
                            streak = (wsum <= th) ? streak + 1 : 0;
                            if (streak >= need) begin
                                ev = e; ev_st = ST_LOCK;
                            end else begin
                                wins++;
                                if (tmo != 0 && wins == tmo) begin
                                    ev = e; ev_st = ST_FAIL;
                                end
                            end
                            wn = 0; wsum = 0;
                        end
                    end
                end
            end
            last = (ev >= 0) ? ev : NE - 1;

            start_cfg(lms, t % 4, tmo, th, 65535, cnv, frz);
            check("rnd_start", STATE, ST_RST);
            for (int e = 1; e <= last; e++) begin
                SAMPLE_VLD = vld_a[e];
                ERR_ABS    = err_a[e];
                step();
                est = exp_state_at(e, e_rls, ev, ev_st);
                check("rnd_state", STATE, est);
                check("rnd_en", CORE_EN,
                      vld_a[e] && (est == ST_LMS || est == ST_RLS || (est == ST_LOCK && !frz)));
            end
            SAMPLE_VLD = 1'b0;
            ABORT = 1'b1; step(); ABORT = 1'b0;
            check("rnd_abort", STATE, ST_IDLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cali_seq_ctrl.md
Name: cali_seq_ctrl

Overview:
Calibration sequencer for the piecewise DCD-RLS/LMS distortion-calibration core.
- Resets the core, runs an LMS acquisition phase, then switches to RLS tracking.
- Monitors quantized |error| over fixed windows to declare lock, detect loss of lock and flag timeout.
- Drives the core's NRST, EN, CALI_MODE_RLS and PSEGS pins.

Parameters:
EW, 12, width of quantized error magnitude ERR_ABS
CW, 16, width of cycle/window counters and their config fields
WIN_LOG2, 4, window length = 2^WIN_LOG2 valid samples
RST_CYC, 4, cycles CORE_NRST is held low in CORE_RST (>=1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
START  in  1  one-cycle pulse; begins calibration (honoured in IDLE or FAIL only)
ABORT  in  1  one-cycle pulse; return to IDLE from any state
SAMPLE_VLD  in  1  ERR_ABS valid this cycle; one core update per valid
ERR_ABS  in  EW  unsigned |error| sample
CFG_PSEGS  in  2  segment-count select, latched on START
CFG_LMS_CYC  in  CW  valid samples spent in LMS_ACQ, latched on START
CFG_TIMEOUT  in  CW  max windows in RLS_TRK before FAIL, latched on START; 0 = never
CFG_LOCK_TH  in  EW+WIN_LOG2  window sum <= this counts as converged
CFG_UNLOCK_TH  in  EW+WIN_LOG2  window sum > this in LOCKED = lock lost
CFG_CONV_N  in  4  consecutive converged windows needed for lock; 0 treated as 1
CFG_FREEZE  in  1  1: core frozen (EN=0) while LOCKED
CORE_NRST  out  1  active-low reset to core
CORE_EN  out  1  core update enable
CORE_MODE_RLS  out  1  0 = LMS, 1 = RLS
CORE_PSEGS  out  2  latched CFG_PSEGS
LOCKED  out  1  state == LOCKED
FAIL  out  1  state == FAIL
BUSY  out  1  state in {CORE_RST, LMS_ACQ, RLS_TRK}
STATE  out  3  encoded state
RELOCK_CNT  out  8  number of LOCKED->RLS_TRK transitions since START, saturating at 255

Behaviour:
- Reset values:
  - State: IDLE.
  - Outputs: CORE_NRST=0, CORE_EN=0, CORE_MODE_RLS=0, CORE_PSEGS=0, LOCKED=0, FAIL=0, BUSY=0, RELOCK_CNT=0.
  - Internal: all counters and the accumulator = 0.
- States and encodings: IDLE=0, CORE_RST=1, LMS_ACQ=2, RLS_TRK=3, LOCKED=4, FAIL=5; codes 6-7 go to IDLE.
- Moore outputs decoded from the state register:
  - CORE_NRST=0 in IDLE and CORE_RST; 1 otherwise. FAIL keeps the core's coefficients for debug.
  - CORE_MODE_RLS=1 in RLS_TRK and LOCKED.
  - CORE_EN = SAMPLE_VLD & (state in {LMS_ACQ, RLS_TRK} | (state==LOCKED & !freeze_q)). This is the only combinational path from inputs.
- IDLE/FAIL + START:
  - Latch all CFG_* fields; clear RELOCK_CNT, counters and accumulator.
  - Next state CORE_RST. START in any other state is ignored.
- CORE_RST: lasts exactly RST_CYC cycles, then LMS_ACQ.
- LMS_ACQ:
  - Sample counter increments on SAMPLE_VLD.
  - On the valid sample that makes count == lms_cyc_q, move to RLS_TRK next cycle.
  - lms_cyc_q=0: CORE_RST exits directly to RLS_TRK.
- Window monitor (active in RLS_TRK and LOCKED):
  - On SAMPLE_VLD, add ERR_ABS to an (EW+WIN_LOG2)-bit accumulator; this width cannot overflow.
  - On the 2^WIN_LOG2-th valid sample, the window closes. Compare the sum including that sample, then clear the accumulator and sample counter.
  - The accumulator and counter clear on every state entry.
- RLS_TRK, at window close:
  - sum <= lock_th_q: conv_cnt++; otherwise conv_cnt=0.
  - When conv_cnt reaches max(conv_n_q,1), go to LOCKED.
  - Otherwise win_cnt++. If timeout_q != 0 and win_cnt reaches timeout_q, go to FAIL.
  - Lock takes priority over timeout in the same window.
- LOCKED, at window close:
  - sum > unlock_th_q: go to RLS_TRK; conv_cnt=0, win_cnt=0, RELOCK_CNT++ (saturating at 255).
  - Monitoring continues while frozen.
- ABORT: in any state, next state IDLE. ABORT wins over START, window close and timeout in the same cycle.
- RST asserted mid-operation returns to the reset values on the next edge.
- Samples with SAMPLE_VLD=0 are ignored by all counters and by the accumulator.

Test Plan:
1. RST, then START with LMS_CYC=10, RST_CYC=4, SAMPLE_VLD=1 constant:
   - CORE_NRST low for 4 cycles.
   - CORE_MODE_RLS rises exactly 10 cycles after CORE_NRST rises.
   - CORE_PSEGS equals the latched value; later CFG_PSEGS changes have no effect.
2. RLS_TRK with ERR_ABS=3, WIN_LOG2=4, LOCK_TH=48, CONV_N=2 -> LOCKED asserts after exactly 32 valid samples. Repeat with LOCK_TH=47 -> no lock.
3. Same setup, LOCK_TH=0, TIMEOUT=5 -> FAIL after 80 valid samples, with CORE_NRST=1 and CORE_EN=0. A following START -> CORE_RST.
4. LOCKED with FREEZE=1, then one window of ERR_ABS=100 with UNLOCK_TH=1000:
   - CORE_EN=0 throughout LOCKED.
   - Next state RLS_TRK, RELOCK_CNT=1, CORE_EN follows SAMPLE_VLD again.
5. SAMPLE_VLD toggling 1/0 in LMS_ACQ with LMS_CYC=8 -> exit after 16 cycles. CORE_EN mirrors SAMPLE_VLD.
6. ABORT in the same cycle as a lock-qualifying window close, and separately START while BUSY -> IDLE next cycle / START ignored. LMS_CYC=0 -> CORE_RST goes straight to RLS_TRK.
